// File: rtl/seq_nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// seq_nonrestoring_divider
//
// Multi-cycle integer divider producing one quotient bit per clock using the
// non-restoring algorithm on operand magnitudes. Fixed latency of WIDTH+1
// cycles from the accepting edge to the done pulse. A zero divisor is
// resolved in the accepting cycle without entering the iteration loop.
//
// Build option:
//   DIV_SIGNED_EN  defined   -> two's complement operands/results, truncation
//                               toward zero, remainder takes dividend sign.
//                  undefined -> unsigned operands/results.
//
// Parameters:
//   WIDTH  operand/result width (>= 4)
//   CNT_W  iteration counter width (>= clog2(WIDTH+1))
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        operation request, sampled only while idle
//   dividend     numerator, captured with an accepted start
//   divisor      denominator, captured with an accepted start
//   busy         high while an operation is in flight
//   done         one-cycle pulse, results valid
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   div_by_zero  last completed operation had a zero divisor
// -----------------------------------------------------------------------------
module seq_nonrestoring_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

`ifdef DIV_SIGNED_EN
   // Two's complement negate when neg is set, pass-through otherwise.
   function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      if (neg) begin
         r = ~v + WIDTH'(1);
      end else begin
         r = v;
      end
      return r;
   endfunction
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   p_q, p_d;        // signed partial remainder
   logic [WIDTH-1:0] qm_q, qm_d;      // magnitude quotient shift register
   logic [WIDTH-1:0] dm_q, dm_d;      // divisor magnitude
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
`endif

   logic [WIDTH:0]   p_sh;
   logic [WIDTH:0]   p_new;
   logic [WIDTH-1:0] rem_mag;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

   // One iteration step plus remainder correction, purely combinational.
   always_comb begin
      // The shifted value may need WIDTH+2 bits, but the add/sub result always
      // lies in [-|d|, |d|), so computing modulo 2^(WIDTH+1) is exact. The
      // add/sub choice uses the pre-shift sign, which equals the shifted sign.
      p_sh = {p_q[WIDTH-1:0], qm_q[WIDTH-1]};
      if (p_q[WIDTH]) begin
         p_new = p_sh + {1'b0, dm_q};
      end else begin
         p_new = p_sh - {1'b0, dm_q};
      end
      if (p_q[WIDTH]) begin
         rem_mag = p_q[WIDTH-1:0] + dm_q;
      end else begin
         rem_mag = p_q[WIDTH-1:0];
      end
`ifdef DIV_SIGNED_EN
      dvd_mag = neg_if(dividend[WIDTH-1], dividend);
      dvs_mag = neg_if(divisor[WIDTH-1], divisor);
`else
      dvd_mag = dividend;
      dvs_mag = divisor;
`endif
   end

   // Next-state and output-register logic for the divider FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      qm_d    = qm_q;
      dm_d    = dm_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (divisor == {WIDTH{1'b0}}) begin
                  // Zero divide resolves immediately; no iterations.
                  quo_d  = {WIDTH{1'b1}};
                  rem_d  = dividend;
                  dbz_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
                  cnt_d   = CNT_W'(WIDTH);
                  p_d     = {(WIDTH+1){1'b0}};
                  qm_d    = dvd_mag;
                  dm_d    = dvs_mag;
`ifdef DIV_SIGNED_EN
                  q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_neg_d = dividend[WIDTH-1];
`endif
               end
            end else begin
               busy_d = 1'b0;
            end
         end
         ST_RUN: begin
            p_d   = p_new;
            qm_d  = {qm_q[WIDTH-2:0], ~p_new[WIDTH]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_FIX: begin
`ifdef DIV_SIGNED_EN
            quo_d = neg_if(q_neg_q, qm_q);
            rem_d = neg_if(r_neg_q, rem_mag);
`else
            quo_d = qm_q;
            rem_d = rem_mag;
`endif
            dbz_d   = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and result registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         p_q     <= {(WIDTH+1){1'b0}};
         qm_q    <= {WIDTH{1'b0}};
         dm_q    <= {WIDTH{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= {WIDTH{1'b0}};
         rem_q   <= {WIDTH{1'b0}};
         dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         qm_q    <= qm_d;
         dm_q    <= dm_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
module tb_seq_nonrestoring_divider;

   localparam int WIDTH = 32;
   localparam int LAT   = 33;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int n_pass;
   int n_total;

   seq_nonrestoring_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Waits for done; caller is already #1 past the accepting edge.
   task automatic wait_done(input int lat_in, output int lat, output logic busy_first,
                            output logic busy_last);
      lat = lat_in;
      busy_first = busy;
      busy_last = busy;
      while (!done && lat < 100) begin
         busy_last = busy;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int lat,
                        output logic busy_first, output logic busy_last);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(0, lat, busy_first, busy_last);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      dividend = 32'd0;
      divisor = 32'd0;
      #3;
      n_total++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0)
         $display("FAIL reset_values got busy=%b done=%b dbz=%b q=%h r=%h want all zero",
                  busy, done, div_by_zero, quotient, remainder);
      else n_pass++;
      #10;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic check_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic edbz, input int elat);
      int lat;
      logic bf, bl;
      do_op(a, b, lat, bf, bl);
      n_total++;
      if (lat !== elat) $display("FAIL %s_latency got %0d want %0d", name, lat, elat);
      else n_pass++;
      n_total++;
      if (quotient !== eq || remainder !== er || div_by_zero !== edbz)
         $display("FAIL %s_result got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                  name, quotient, remainder, div_by_zero, eq, er, edbz);
      else n_pass++;
   endtask

   task automatic test_basic();
      int lat;
      logic bf, bl;
      do_op(32'd100, 32'd7, lat, bf, bl);
      n_total++;
      if (lat !== LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT);
      else n_pass++;
      n_total++;
      if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0)
         $display("FAIL basic_result got q=%h r=%h dbz=%b want q=e r=2 dbz=0",
                  quotient, remainder, div_by_zero);
      else n_pass++;
      n_total++;
      if (bf !== 1'b1 || bl !== 1'b1 || busy !== 1'b0)
         $display("FAIL basic_busy got first=%b last=%b at_done=%b want 1 1 0", bf, bl, busy);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2)
         $display("FAIL basic_hold got done=%b q=%h r=%h want done=0 q=e r=2",
                  done, quotient, remainder);
      else n_pass++;
      check_op("zero_dividend", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, LAT);
      check_op("all_ones_by_one", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, LAT);
   endtask

   task automatic test_signedness();
`ifdef DIV_SIGNED_EN
      check_op("neg_dividend", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, LAT);
      check_op("neg_divisor", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, LAT);
      check_op("min_by_minus1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, LAT);
`else
      check_op("big_dividend", 32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0, LAT);
      check_op("big_divisor", 32'd100, 32'hFFFFFFF9, 32'd0, 32'd100, 1'b0, LAT);
      check_op("min_by_max", 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, LAT);
`endif
   endtask

   task automatic test_div_zero();
      int lat;
      logic bf, bl;
      do_op(32'd7, 32'd0, lat, bf, bl);
      n_total++;
      if (lat !== 0) $display("FAIL dz_latency got %0d want 0", lat);
      else n_pass++;
      n_total++;
      if (quotient !== 32'hFFFFFFFF || remainder !== 32'd7 || div_by_zero !== 1'b1 || busy !== 1'b0)
         $display("FAIL dz_result got q=%h r=%h dbz=%b busy=%b want q=ffffffff r=7 dbz=1 busy=0",
                  quotient, remainder, div_by_zero, busy);
      else n_pass++;
      check_op("after_dz", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT);
   endtask

   task automatic test_ignored_start();
      int lat;
      int pulses;
      logic bf, bl;
      dividend = 32'd1000;
      divisor  = 32'd10;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      dividend = 32'd55;
      divisor  = 32'd5;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(5, lat, bf, bl);
      n_total++;
      if (lat !== LAT) $display("FAIL ignored_latency got %0d want %0d", lat, LAT);
      else n_pass++;
      n_total++;
      if (quotient !== 32'd100 || remainder !== 32'd0)
         $display("FAIL ignored_result got q=%h r=%h want q=64 r=0", quotient, remainder);
      else n_pass++;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      n_total++;
      if (pulses !== 0) $display("FAIL ignored_extra_activity got %0d cycles want 0", pulses);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lat;
      logic bf, bl;
      do_op(32'd100, 32'd7, lat, bf, bl);
      // Still in the done cycle: issue the next operation immediately.
      dividend = 32'd1000;
      divisor  = 32'd10;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_total++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done);
      else n_pass++;
      wait_done(0, lat, bf, bl);
      n_total++;
      if (lat !== LAT) $display("FAIL b2b_latency got %0d want %0d", lat, LAT);
      else n_pass++;
      n_total++;
      if (quotient !== 32'd100 || remainder !== 32'd0)
         $display("FAIL b2b_result got q=%h r=%h want q=64 r=0", quotient, remainder);
      else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      dividend = 32'd1000;
      divisor  = 32'd10;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      n_total++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0)
         $display("FAIL midreset_clear got busy=%b done=%b dbz=%b q=%h r=%h want all zero",
                  busy, done, div_by_zero, quotient, remainder);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0)
         $display("FAIL midreset_no_done got busy=%b done=%b want 0 0", busy, done);
      else n_pass++;
      check_op("after_reset", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, LAT);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_basic();
      test_signedness();
      test_div_zero();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
